move_selector: RTL and testbench
================================

Name: move_selector

Overview:
- Player-input front end that produces the mark/position move stream consumed by the grid recorder.
- Tracks a 3x3 cursor from push-button edges and tracks whose turn it is.
- Validates each confirm against the current displayed grid and emits a one-cycle move pulse.
- Sits between the debounced button block and the recorder; the recorder's grid outputs feed back into this block's cell inputs.

Parameters:
- SETTLE_CYCLES, 2, cycles after a move during which input is ignored so the recorder's registered grid can update (1..15).
- INVALID_HOLD, 8, cycles the invalid flag stays high after a rejected confirm (1..255).
- TURN_TIMEOUT, 1000, idle cycles in SELECT before an automatic move (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- game_state  in  1  1 = game running, 0 = halted
- btn_up, btn_down, btn_left, btn_right, btn_confirm  in  1 each  debounced, synchronous button levels
- x0..x8  in  2 each  current grid cells: 01 = O, 10 = X, 00 = empty
- mark  out  2  move pulse: 01 = O, 10 = X, 00 = none
- position  out  4  cell index 0-8 of the move; valid while mark != 00
- whosTurn  out  1  1 = X, 0 = O
- cursor  out  4  highlighted cell, 0-8
- invalid  out  1  rejected-confirm indicator

Behaviour:
- Reset values (async, rst=0): state IDLE, mark=00, position=0, whosTurn=0, cursor=4, invalid=0, all counters 0, button-history registers 0.
- Edge detection: an action fires on a 0->1 transition of a registered button level. A button held through reset fires once, on its first rising edge after release and re-press.
- Simultaneous edges: only one action per cycle, priority confirm > up > down > left > right. Losing edges are discarded, not queued.
- Cursor moves (row = cursor/3, col = cursor%3):
  - up: cursor-3, wrapping 0->6, 1->7, 2->8.
  - down: cursor+3, wrapping 6->0, 7->1, 8->2.
  - left: col-1 within the row, wrapping 3->5.
  - right: col+1 within the row, wrapping 5->3.
  - Cursor is never outside 0-8.
- Selected cell = x[cursor], combinational mux.
- IDLE: cursor held at 4, whosTurn held at 0, mark=00. Goes to SELECT on the first cycle game_state=1.
- SELECT: cursor actions apply. On confirm:
  - Selected cell == 00: go to COMMIT.
  - Otherwise: invalid=1 for exactly INVALID_HOLD cycles, then 0; state stays SELECT.
  - A new rejected confirm while invalid=1 restarts the hold count.
  - Any valid confirm clears invalid immediately.
- COMMIT (1 cycle): registered outputs mark = whosTurn ? 10 : 01 and position = cursor.
  - Latency: confirm edge sampled in cycle N -> mark valid in cycle N+1 for exactly one cycle.
  - whosTurn toggles at the end of COMMIT. Next state SETTLE.
- SETTLE: mark=00. All button edges are consumed and discarded for SETTLE_CYCLES cycles, then SELECT.
- game_state=0 in any state: next state IDLE. A confirm sampled in the same cycle as game_state=0 does not commit. A COMMIT already in progress still completes its single pulse.
- Repeated moves to cells the recorder has since cleared are legal; validity is judged only on the current x inputs.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined: in SELECT, an idle counter increments each cycle and resets on any accepted action or state change. At TURN_TIMEOUT it scans cells from cursor upward with wrap 8->0 for the first empty cell.
  - Empty cell found: cursor moves there and COMMIT follows with that position.
  - No empty cell: no move, counter restarts.
- Undefined: no counter, no automatic moves; TURN_TIMEOUT is unused.

Test Plan:
- Reset, game_state=1, empty grid, press confirm -> mark=01, position=4 for one cycle; whosTurn=1 afterwards.
- From cursor 4 press up, up, left -> cursor 1, 7, 6; then right -> 7; then down -> 1.
- Set x4=01, cursor 4, press confirm -> mark stays 00, invalid high exactly INVALID_HOLD=8 cycles, whosTurn unchanged.
- Press confirm and down in the same cycle on an empty cell -> commit at the original cursor, cursor unchanged.
- Press a button during SETTLE (SETTLE_CYCLES=2) -> ignored; cursor and mark unchanged.
- With TURN_TIMEOUT_EN, TURN_TIMEOUT=20, cursor 7, x7=x8=10, x0=00 -> after 20 idle cycles mark=whosTurn's mark, position=0, cursor=0.

Source files
------------

// File: rtl/move_selector.sv
// move_selector: button-driven 3x3 cursor, turn tracking and validated one-cycle move pulses for the grid recorder.
// Build macro TURN_TIMEOUT_EN adds an automatic move to the next empty cell after TURN_TIMEOUT idle cycles.
module move_selector #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned INVALID_HOLD  = 8,
   parameter int unsigned TURN_TIMEOUT  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_state,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_confirm,
   input  logic [1:0] x0,
   input  logic [1:0] x1,
   input  logic [1:0] x2,
   input  logic [1:0] x3,
   input  logic [1:0] x4,
   input  logic [1:0] x5,
   input  logic [1:0] x6,
   input  logic [1:0] x7,
   input  logic [1:0] x8,
   output logic [1:0] mark,
   output logic [3:0] position,
   output logic       whosTurn,
   output logic [3:0] cursor,
   output logic       invalid
);

   localparam int unsigned BTN_W  = 5;
   localparam int unsigned SET_W  = 4;
   localparam int unsigned INV_W  = 8;
   localparam logic [3:0]  CENTER = 4'd4;

   typedef enum logic [1:0] {IDLE, SELECT, COMMIT, SETTLE} state_t;

   state_t           state;
   logic [BTN_W-1:0] btn_raw;
   logic [BTN_W-1:0] btn_q;
   logic [BTN_W-1:0] btn_prev;
   logic [BTN_W-1:0] btn_armed;
   logic [BTN_W-1:0] btn_edge;
   logic [1:0]       sel_cell;
   logic [1:0]       turn_mark;
   logic [SET_W-1:0] settle_cnt;
   logic [INV_W-1:0] inv_cnt;

   // Bit order gives priority: confirm, up, down, left, right.
   assign btn_raw   = {btn_confirm, btn_up, btn_down, btn_left, btn_right};
   // A button only arms once it has been seen released, so a press held through reset cannot fire.
   assign btn_edge  = btn_q & ~btn_prev & btn_armed;
   assign turn_mark = whosTurn ? 2'b10 : 2'b01;

   always_comb begin
      sel_cell = 2'b00;
      case (cursor)
         4'd0:    sel_cell = x0;
         4'd1:    sel_cell = x1;
         4'd2:    sel_cell = x2;
         4'd3:    sel_cell = x3;
         4'd4:    sel_cell = x4;
         4'd5:    sel_cell = x5;
         4'd6:    sel_cell = x6;
         4'd7:    sel_cell = x7;
         4'd8:    sel_cell = x8;
         default: sel_cell = 2'b00;
      endcase
   end

   function automatic logic [3:0] step_up(input logic [3:0] c);
      return (c < 4'd3) ? c + 4'd6 : c - 4'd3;
   endfunction

   function automatic logic [3:0] step_down(input logic [3:0] c);
      return (c > 4'd5) ? c - 4'd6 : c + 4'd3;
   endfunction

   function automatic logic [3:0] step_left(input logic [3:0] c);
      return (c inside {4'd0, 4'd3, 4'd6}) ? c + 4'd2 : c - 4'd1;
   endfunction

   function automatic logic [3:0] step_right(input logic [3:0] c);
      return (c inside {4'd2, 4'd5, 4'd8}) ? c - 4'd2 : c + 4'd1;
   endfunction

`ifdef TURN_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TURN_TIMEOUT + 1);

   logic [8:0][1:0]   cells;
   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_expired;
   logic              scan_found;
   logic [3:0]        scan_pos;
   logic [4:0]        scan_idx;

   assign cells        = {x8, x7, x6, x5, x4, x3, x2, x1, x0};
   assign idle_expired = (idle_cnt == IDLE_W'(TURN_TIMEOUT - 1));

   // First empty cell scanning upward from the cursor with wrap; descending loop lets the nearest win.
   always_comb begin
      scan_found = 1'b0;
      scan_pos   = cursor;
      scan_idx   = '0;
      for (int k = 8; k >= 0; k--) begin
         scan_idx = 5'(cursor) + 5'(k);
         if (scan_idx >= 5'd9) scan_idx = scan_idx - 5'd9;
         if (cells[scan_idx[3:0]] == 2'b00) begin
            scan_found = 1'b1;
            scan_pos   = scan_idx[3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if (state != SELECT || !game_state || (|btn_edge) || idle_expired) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TURN_TIMEOUT;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         mark       <= 2'b00;
         position   <= 4'd0;
         whosTurn   <= 1'b0;
         cursor     <= CENTER;
         invalid    <= 1'b0;
         settle_cnt <= '0;
         inv_cnt    <= '0;
         btn_q      <= '0;
         btn_prev   <= '0;
         btn_armed  <= '0;
      end else begin
         btn_q     <= btn_raw;
         btn_prev  <= btn_q;
         btn_armed <= btn_armed | ~btn_raw;

         // Invalid flag drops when its hold count runs out; a reject below reloads it.
         if (inv_cnt != '0) begin
            inv_cnt <= inv_cnt - INV_W'(1);
            if (inv_cnt == INV_W'(1)) invalid <= 1'b0;
         end

         case (state)
            IDLE: begin
               mark       <= 2'b00;
               cursor     <= CENTER;
               whosTurn   <= 1'b0;
               settle_cnt <= '0;
               if (game_state) state <= SELECT;
            end
            SELECT: begin
               mark <= 2'b00;
               if (!game_state) begin
                  state <= IDLE;
               end else if (btn_edge[4]) begin
                  if (sel_cell == 2'b00) begin
                     state    <= COMMIT;
                     mark     <= turn_mark;
                     position <= cursor;
                     invalid  <= 1'b0;
                     inv_cnt  <= '0;
                  end else begin
                     invalid <= 1'b1;
                     inv_cnt <= INV_W'(INVALID_HOLD);
                  end
               end else if (btn_edge[3]) begin
                  cursor <= step_up(cursor);
               end else if (btn_edge[2]) begin
                  cursor <= step_down(cursor);
               end else if (btn_edge[1]) begin
                  cursor <= step_left(cursor);
               end else if (btn_edge[0]) begin
                  cursor <= step_right(cursor);
               end
`ifdef TURN_TIMEOUT_EN
               else if (idle_expired && scan_found) begin
                  state    <= COMMIT;
                  cursor   <= scan_pos;
                  position <= scan_pos;
                  mark     <= turn_mark;
               end
`endif
            end
            COMMIT: begin
               // The pulse is already on mark this cycle; it completes even if the game halts.
               mark       <= 2'b00;
               whosTurn   <= ~whosTurn;
               settle_cnt <= '0;
               state      <= game_state ? SETTLE : IDLE;
            end
            SETTLE: begin
               mark <= 2'b00;
               if (!game_state) begin
                  state <= IDLE;
               end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                  settle_cnt <= '0;
                  state      <= SELECT;
               end else begin
                  settle_cnt <= settle_cnt + SET_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_selector.sv
// tb_move_selector: randomized presses against a row/column game model; move pulses checked through a scoreboard.
`timescale 1ns/1ps
module tb_move_selector;

   localparam int unsigned SETTLE  = 2;
   localparam int unsigned HOLD    = 8;
   localparam int unsigned TIMEOUT = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       game_state;
   logic       btn_up, btn_down, btn_left, btn_right, btn_confirm;
   logic [1:0] grid [9];
   logic [1:0] mark;
   logic [3:0] position;
   logic       whosTurn;
   logic [3:0] cursor;
   logic       invalid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [1:0] m;
      logic [3:0] p;
      int         c;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // Reference game state
   int         m_cur    = 4;
   bit         m_turn   = 1'b0;
   bit         have_rej = 1'b0;
   int         rej_cyc  = 0;
   bit         pend     = 1'b0;
   int         pend_pos = 0;
   logic [1:0] pend_mark;

   move_selector #(
      .SETTLE_CYCLES(SETTLE),
      .INVALID_HOLD (HOLD),
      .TURN_TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .game_state (game_state),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_confirm(btn_confirm),
      .x0         (grid[0]),
      .x1         (grid[1]),
      .x2         (grid[2]),
      .x3         (grid[3]),
      .x4         (grid[4]),
      .x5         (grid[5]),
      .x6         (grid[6]),
      .x7         (grid[7]),
      .x8         (grid[8]),
      .mark       (mark),
      .position   (position),
      .whosTurn   (whosTurn),
      .cursor     (cursor),
      .invalid    (invalid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every nonzero mark must match the oldest expected move, on the expected cycle.
   always @(negedge clk) begin
      if (rst === 1'b1 && mark !== 2'b00) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL move_pulse: unexpected mark=%b pos=%0d at cycle %0d", mark, position, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (mark !== mon_e.m || position !== mon_e.p || cyc != mon_e.c) begin
               errors++;
               $display("FAIL move_pulse: got mark=%b pos=%0d cycle=%0d, expected mark=%b pos=%0d cycle=%0d",
                        mark, position, cyc, mon_e.m, mon_e.p, mon_e.c);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_btns(input logic [4:0] b);
      {btn_confirm, btn_up, btn_down, btn_left, btn_right} = b;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Game rules: priority confirm > up > down > left > right, moves wrap within row/column.
   task automatic model_apply(input logic [4:0] b, input int act);
      int   row;
      int   col;
      exp_t e;
      row = m_cur / 3;
      col = m_cur % 3;
      if (b[4]) begin
         if (grid[m_cur] == 2'b00) begin
            e.m = m_turn ? 2'b10 : 2'b01;
            e.p = 4'(m_cur);
            e.c = act;
            sb.push_back(e);
            pend      = 1'b1;
            pend_pos  = m_cur;
            pend_mark = e.m;
            m_turn    = !m_turn;
            have_rej  = 1'b0;
         end else begin
            have_rej = 1'b1;
            rej_cyc  = act;
         end
      end else begin
         if (b[3])      row = (row + 2) % 3;
         else if (b[2]) row = (row + 1) % 3;
         else if (b[1]) col = (col + 2) % 3;
         else if (b[0]) col = (col + 1) % 3;
         m_cur = row * 3 + col;
      end
   endtask

   // One-cycle press; the action lands on the clock after release, then the recorder writes the cell.
   task automatic do_press(input logic [4:0] b, input bit drop);
      @(posedge clk); #1;
      set_btns(b);
      @(posedge clk); #1;
      set_btns(5'b0);
      if (drop) begin
         game_state = 1'b0;
         m_cur      = 4;
         m_turn     = 1'b0;
      end else begin
         model_apply(b, cyc + 1);
      end
      @(posedge clk); #1;
      if (pend) begin
         grid[pend_pos] = pend_mark;
         pend           = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      bit exp_inv;
      @(negedge clk);
      exp_inv = have_rej && ((cyc - rej_cyc) < int'(HOLD));
      chk({tag, "_cursor"}, 32'(cursor), 32'(m_cur));
      chk({tag, "_turn"}, 32'(whosTurn), 32'(m_turn));
      chk({tag, "_invalid"}, 32'(invalid), 32'(exp_inv));
   endtask

   initial begin
      int   inv_cnt;
      int   r;
      int   sel;
      logic [4:0] b;
      exp_t e;

      rst        = 1'b0;
      game_state = 1'b1;
      set_btns(5'b0);
      btn_up     = 1'b1;
      for (int i = 0; i < 9; i++) grid[i] = 2'b00;

      repeat (3) @(negedge clk);
      chk("reset_mark", 32'(mark), 32'd0);
      chk("reset_position", 32'(position), 32'd0);
      chk("reset_turn", 32'(whosTurn), 32'd0);
      chk("reset_cursor", 32'(cursor), 32'd4);
      chk("reset_invalid", 32'(invalid), 32'd0);

      @(posedge clk); #1;
      rst = 1'b1;
      idle(5);
      @(negedge clk);
      chk("held_through_reset_cursor", 32'(cursor), 32'd4);
      btn_up = 1'b0;
      idle(3);

      // First move on an empty grid
      do_press(5'b10000, 1'b0);
      idle(4);
      check_model("first_move");
      chk("first_move_turn_x", 32'(whosTurn), 32'd1);

      // Cursor walk 4 -> 1 -> 7 -> 6 -> 7 -> 1
      do_press(5'b01000, 1'b0); idle(2); check_model("walk_up1");    chk("walk_up1_const", 32'(cursor), 32'd1);
      do_press(5'b01000, 1'b0); idle(2); check_model("walk_up2");    chk("walk_up2_const", 32'(cursor), 32'd7);
      do_press(5'b00010, 1'b0); idle(2); check_model("walk_left");   chk("walk_left_const", 32'(cursor), 32'd6);
      do_press(5'b00001, 1'b0); idle(2); check_model("walk_right");  chk("walk_right_const", 32'(cursor), 32'd7);
      do_press(5'b00100, 1'b0); idle(2); check_model("walk_down");   chk("walk_down_const", 32'(cursor), 32'd1);

      // Rejected confirm on occupied centre
      do_press(5'b00100, 1'b0); idle(2); check_model("to_center");
      do_press(5'b10000, 1'b0);
      inv_cnt = 0;
      repeat (14) begin
         @(negedge clk);
         if (invalid === 1'b1) inv_cnt++;
      end
      chk("invalid_hold_cycles", 32'(inv_cnt), 32'(HOLD));
      chk("reject_turn_kept", 32'(whosTurn), 32'd1);
      check_model("after_reject");

      // Confirm and down together on an empty cell
      do_press(5'b00001, 1'b0); idle(2); check_model("to_cell5");
      do_press(5'b10100, 1'b0); idle(4); check_model("confirm_down");
      chk("confirm_down_cursor", 32'(cursor), 32'd5);

      // Press during settle is discarded
      do_press(5'b00010, 1'b0); idle(2); check_model("to_cell4");
      do_press(5'b00010, 1'b0); idle(2); check_model("to_cell3");
      do_press(5'b10000, 1'b0);
      btn_down = 1'b1;
      @(posedge clk); #1;
      btn_down = 1'b0;
      idle(4);
      check_model("settle_ignore");
      chk("settle_ignore_cursor", 32'(cursor), 32'd3);

      // Confirm in the same cycle the game halts does not commit
      do_press(5'b01000, 1'b0); idle(2); check_model("to_cell0");
      do_press(5'b10000, 1'b1);
      idle(2);
      check_model("halt_confirm");
      chk("halt_cursor_center", 32'(cursor), 32'd4);
      game_state = 1'b1;
      idle(3);

`ifdef TURN_TIMEOUT_EN
      // Idle timeout from cursor 7 with 7 and 8 taken wraps to cell 0
      grid[7] = 2'b10;
      grid[8] = 2'b10;
      grid[0] = 2'b00;
      do_press(5'b00100, 1'b0);
      e.m = m_turn ? 2'b10 : 2'b01;
      e.p = 4'd0;
      e.c = cyc + int'(TIMEOUT);
      sb.push_back(e);
      m_turn = !m_turn;
      m_cur  = 0;
      idle(int'(TIMEOUT) + 4);
      grid[0] = e.m;
      check_model("timeout_move");
      chk("timeout_cursor", 32'(cursor), 32'd0);
`endif

      // Randomized play
      for (int it = 0; it < 220; it++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            for (int i = 0; i < 9; i++) begin
               sel = $urandom_range(0, 3);
               grid[i] = (sel == 2) ? 2'b01 : (sel == 3) ? 2'b10 : 2'b00;
            end
         end else if (r < 12) begin
            @(posedge clk); #1;
            game_state = 1'b0;
            m_cur      = 4;
            m_turn     = 1'b0;
            idle(3);
            check_model("rand_halt");
            game_state = 1'b1;
            idle(3);
         end else begin
            if ($urandom_range(0, 9) < 7) begin
               sel = $urandom_range(0, 5);
               b   = (sel < 2) ? 5'b10000 : 5'(1 << (sel - 2));
            end else begin
               b = 5'($urandom_range(1, 31));
            end
            do_press(b, 1'b0);
            idle($urandom_range(3, 10));
            check_model("rand");
         end
      end

      idle(5);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
